// File: rtl/d8m_raw_packetiser_if.sv
// Avalon-ST video source/sink bundle carried between the packetiser and the ingest sink.
interface d8m_raw_packetiser_if #(
  parameter int DATA_W = 12
) ();
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              sop;
  logic              eop;
  logic              ready;

  modport master (output data, valid, sop, eop, input ready);
  modport slave  (input data, valid, sop, eop, output ready);
endinterface

// File: rtl/d8m_raw_packetiser.sv
// D8M raw FVAL/LVAL pixel bus to Avalon-ST video packets with frame-size measurement.
// IDLE wait FVAL rise | CTRL dims packet | HDR video sop | STREAM pixels | TERM eop after overflow | DROP skip frame
module d8m_raw_packetiser #(
  parameter int DATA_W     = 12,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_W-1:0]     cam_d,
  input  logic                  cam_fval,
  input  logic                  cam_lval,
  input  logic                  enable,
  input  logic                  clear,
  d8m_raw_packetiser_if.master  st,
  output logic                  overflow,
  output logic [15:0]           frame_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CTRL   = 3'd1,
    HDR    = 3'd2,
    STREAM = 3'd3,
    TERM   = 3'd4,
    DROP   = 3'd5
  } state_t;

  state_t state, state_next;

  logic [DATA_W-1:0] d_r;
  logic              fval_r, fval_rr, lval_r, lval_rr, armed;
  logic              fval_rise, fval_fall, lval_rise, lval_fall, pix_vld;

  logic [15:0] width_cnt, height_cnt, width_l, height_l;
  logic        line_done, dims_valid, frame_bad;

  logic [DATA_W-1:0] hold_data;
  logic              hold_vld, hold_load, hold_clr;
  logic [3:0]        beat_cnt;
  logic [3:0]        nib;

  logic              wr_req, wr_en, wr_sop, wr_eop, ovf_pix, ovf_event;
  logic [DATA_W-1:0] wr_data;

  logic [DATA_W+1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic [DATA_W+1:0] rd_word;
  logic              full, empty, rd, can_wr;
  logic              in_ctrl, pkt_is_ctrl, frame_inc;

  // Edge registers reset high and must see two low samples before a rise counts,
  // so a frame already in progress at reset release is ignored entirely.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_r     <= '0;
      fval_r  <= 1'b1;
      fval_rr <= 1'b1;
      lval_r  <= 1'b0;
      lval_rr <= 1'b0;
      armed   <= 1'b0;
    end else begin
      d_r     <= cam_d;
      fval_r  <= cam_fval;
      fval_rr <= fval_r;
      lval_r  <= cam_lval;
      lval_rr <= lval_r;
      armed   <= armed | (!fval_r & !fval_rr);
    end
  end

  assign fval_rise = armed & fval_r & !fval_rr;
  assign fval_fall = armed & !fval_r & fval_rr;
  assign lval_rise = fval_r & lval_r & !lval_rr;
  assign lval_fall = lval_rr & !lval_r;
  assign pix_vld   = fval_r & lval_r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      width_cnt  <= '0;
      height_cnt <= '0;
      line_done  <= 1'b0;
      width_l    <= '0;
      height_l   <= '0;
      dims_valid <= 1'b0;
      frame_bad  <= 1'b0;
    end else begin
      if (fval_rise) begin
        width_cnt  <= pix_vld ? 16'd1 : 16'd0;
        height_cnt <= lval_rise ? 16'd1 : 16'd0;
        line_done  <= 1'b0;
        frame_bad  <= (state != IDLE) | !enable;
      end else begin
        if (pix_vld && !line_done && width_cnt != 16'hFFFF)
          width_cnt <= width_cnt + 16'd1;
        if (lval_rise && height_cnt != 16'hFFFF)
          height_cnt <= height_cnt + 16'd1;
        if (lval_fall)
          line_done <= 1'b1;
        if (ovf_event)
          frame_bad <= 1'b1;
      end
      if (fval_fall) begin
        width_l    <= width_cnt;
        height_l   <= height_cnt;
        dims_valid <= !(frame_bad | ovf_event);
      end
    end
  end

  always_comb begin
    nib = 4'h0;
    case (beat_cnt)
      4'd0:    nib = 4'hF;
      4'd1:    nib = width_l[15:12];
      4'd2:    nib = width_l[11:8];
      4'd3:    nib = width_l[7:4];
      4'd4:    nib = width_l[3:0];
      4'd5:    nib = height_l[15:12];
      4'd6:    nib = height_l[11:8];
      4'd7:    nib = height_l[7:4];
      4'd8:    nib = height_l[3:0];
      default: nib = 4'h0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (fval_rise) state_next = !enable ? DROP : (dims_valid ? CTRL : HDR);
      CTRL:   if (ovf_event) state_next = TERM;
              else if (wr_en && beat_cnt == 4'd8) state_next = HDR;
      HDR:    state_next = ovf_event ? TERM : STREAM;
      STREAM: if (ovf_event) state_next = TERM;
              else if (fval_fall) state_next = IDLE;
      TERM:   if (can_wr) state_next = fval_r ? DROP : IDLE;
      DROP:   if (fval_fall) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A frame ending during CTRL/HDR is treated as truncated so the writer never waits on a missed fall.
  always_comb begin
    wr_req    = 1'b0;
    wr_data   = '0;
    wr_sop    = 1'b0;
    wr_eop    = 1'b0;
    ovf_pix   = 1'b0;
    hold_load = 1'b0;
    hold_clr  = 1'b0;
    case (state)
      CTRL: begin
        if (pix_vld || fval_fall) ovf_pix = 1'b1;
        else begin
          wr_req  = 1'b1;
          wr_data = {{(DATA_W-4){1'b0}}, nib};
          wr_sop  = (beat_cnt == 4'd0);
          wr_eop  = (beat_cnt == 4'd8);
        end
      end
      HDR: begin
        if (pix_vld || fval_fall) ovf_pix = 1'b1;
        else begin
          wr_req = 1'b1;
          wr_sop = 1'b1;
        end
      end
      STREAM: begin
        if (fval_fall) begin
          wr_req   = 1'b1;
          wr_data  = hold_vld ? hold_data : '0;
          wr_eop   = 1'b1;
          hold_clr = 1'b1;
        end else if (pix_vld) begin
          hold_load = 1'b1;
          wr_req    = hold_vld;
          wr_data   = hold_data;
        end
      end
      TERM: begin
        wr_req = can_wr;
        wr_eop = 1'b1;
      end
      default: ;
    endcase
  end

  assign can_wr    = !full | rd;
  assign wr_en     = wr_req & can_wr;
  assign ovf_event = ovf_pix | (wr_req & !can_wr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_vld  <= 1'b0;
      hold_data <= '0;
      beat_cnt  <= '0;
    end else begin
      if (hold_clr || ovf_event) hold_vld <= 1'b0;
      else if (hold_load) begin
        hold_vld  <= 1'b1;
        hold_data <= d_r;
      end
      if (state != CTRL) beat_cnt <= '0;
      else if (wr_en)    beat_cnt <= beat_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {wr_sop, wr_eop, wr_data};
  end

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign rd_word = mem[rd_ptr[AW-1:0]];
  assign rd      = st.valid & st.ready;

  // Outputs are gated by empty so they read as zero after reset regardless of RAM contents.
  assign st.valid = !empty;
  assign st.sop   = !empty & rd_word[DATA_W+1];
  assign st.eop   = !empty & rd_word[DATA_W];
  assign st.data  = empty ? '0 : rd_word[DATA_W-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd)    rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Control packets are recognised by their 0xF type nibble so only video eops count as frames.
  assign pkt_is_ctrl = st.sop ? (st.data[3:0] == 4'hF) : in_ctrl;
  assign frame_inc   = rd & st.eop & !pkt_is_ctrl;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_ctrl     <= 1'b0;
      overflow    <= 1'b0;
      frame_count <= '0;
    end else begin
      if (rd && st.sop) in_ctrl <= pkt_is_ctrl;
      if (ovf_event)  overflow <= 1'b1;
      else if (clear) overflow <= 1'b0;
      if (clear)          frame_count <= '0;
      else if (frame_inc) frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_d8m_raw_packetiser.sv
// Directed frames into the packetiser; output beats checked against a queue of expected beats.
module tb_d8m_raw_packetiser;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] cam_d;
  logic          cam_fval, cam_lval, enable, clear;
  logic          overflow;
  logic [15:0]   frame_count;

  d8m_raw_packetiser_if #(.DATA_W(DW)) st ();

  d8m_raw_packetiser #(.DATA_W(DW), .FIFO_DEPTH(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cam_d       (cam_d),
    .cam_fval    (cam_fval),
    .cam_lval    (cam_lval),
    .enable      (enable),
    .clear       (clear),
    .st          (st),
    .overflow    (overflow),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  logic [DW+1:0] exp_q[$];
  logic [DW+2:0] cur_word, prev_word;
  logic [DW+1:0] exp_word;
  int            n_cmp = 0;
  int            n_err = 0;
  int            ready_mode = 1;
  bit            prev_stall = 1'b0;
  bit            mon_off = 1'b0;
  bit            mdl_dv = 1'b0;
  int            mdl_w = 0, mdl_h = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       st.ready = 1'b0;
      1:       st.ready = 1'b1;
      default: st.ready = ~st.ready;
    endcase
  end

  // Sink side: pop on every transfer, and hold the beat steady across stalls.
  always @(negedge clk) begin
    if (!reset_n || mon_off) prev_stall = 1'b0;
    else begin
      cur_word = {st.valid, st.sop, st.eop, st.data};
      if (prev_stall) chk("stall_hold", 32'(cur_word), 32'(prev_word));
      if (st.valid && st.ready) begin
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_err++;
          $error("FAIL unexpected_beat: observed sop=%0b eop=%0b data=%0h expected no beat",
                 st.sop, st.eop, st.data);
        end
        if (exp_q.size() != 0) begin
          exp_word = exp_q.pop_front();
          chk("beat", 32'({st.sop, st.eop, st.data}), 32'(exp_word));
        end
      end
      prev_stall = st.valid & !st.ready;
      prev_word  = cur_word;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input bit sop, input bit eop, input int data);
    exp_q.push_back({sop, eop, DW'(data)});
  endtask

  task automatic push_ctrl(input int w, input int h);
    push_beat(1, 0, 'hF);
    for (int i = 3; i >= 0; i--) push_beat(0, 0, (w >> (4 * i)) & 'hF);
    for (int i = 3; i >= 0; i--) push_beat(0, i == 0, (h >> (4 * i)) & 'hF);
  endtask

  task automatic push_frame(input int w, input int h, input int start);
    if (mdl_dv) push_ctrl(mdl_w, mdl_h);
    push_beat(1, 0, 0);
    for (int i = 0; i < w * h; i++) push_beat(0, i == w * h - 1, start + i);
  endtask

  task automatic drive_frame(input int w, input int h, input int start, input int clr_line);
    cam_fval = 1'b1;
    repeat (12) cyc();
    for (int l = 0; l < h; l++) begin
      if (l == clr_line) begin
        clear = 1'b1;
        cyc();
        clear = 1'b0;
      end
      cam_lval = 1'b1;
      for (int p = 0; p < w; p++) begin
        cam_d = DW'(start + l * w + p);
        cyc();
      end
      cam_lval = 1'b0;
      cam_d    = '0;
      repeat (4) cyc();
    end
    cam_fval = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      cyc();
      k++;
    end
    chk(tag, 32'(exp_q.size()), 0);
    repeat (3) cyc();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(st.valid), 0);
    chk({tag, "_sop"}, 32'(st.sop), 0);
    chk({tag, "_eop"}, 32'(st.eop), 0);
    chk({tag, "_data"}, 32'(st.data), 0);
    chk({tag, "_overflow"}, 32'(overflow), 0);
    chk({tag, "_frame_count"}, 32'(frame_count), 0);
  endtask

  initial begin
    st.ready = 1'b0;
    cam_d    = '0;
    cam_fval = 1'b0;
    cam_lval = 1'b0;
    enable   = 1'b0;
    clear    = 1'b0;
    repeat (3) cyc();
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    repeat (5) cyc();
    enable = 1'b1;

    // First frame after reset: video packet only.
    push_frame(4, 2, 1);
    drive_frame(4, 2, 1, -1);
    wait_drain("drain_f1");
    mdl_dv = 1; mdl_w = 4; mdl_h = 2;
    chk("frame_count_f1", 32'(frame_count), 1);

    // Second frame: control packet with the 4x2 dimensions, then video.
    push_frame(4, 2, 1);
    drive_frame(4, 2, 1, -1);
    wait_drain("drain_f2");
    chk("frame_count_f2", 32'(frame_count), 2);
    chk("overflow_f2", 32'(overflow), 0);

    // Long line with the sink stalled: FIFO fills, frame is truncated.
    ready_mode = 0;
    repeat (2) cyc();
    push_ctrl(mdl_w, mdl_h);
    push_beat(1, 0, 0);
    for (int i = 1; i <= 6; i++) push_beat(0, 0, i);
    push_beat(0, 1, 0);
    drive_frame(64, 1, 1, -1);
    chk("overflow_set", 32'(overflow), 1);
    chk("valid_stalled", 32'(st.valid), 1);
    mdl_dv = 0;
    ready_mode = 1;
    wait_drain("drain_ovf");

    // Ready toggling every cycle; no control packet after the truncated frame.
    ready_mode = 2;
    push_frame(4, 2, 'h7F0);
    drive_frame(4, 2, 'h7F0, -1);
    wait_drain("drain_toggle");
    ready_mode = 1;
    repeat (2) cyc();
    mdl_dv = 1; mdl_w = 4; mdl_h = 2;

    // Disabled frame with a clear pulse mid-frame: no output, counters cleared.
    enable = 1'b0;
    drive_frame(4, 2, 'h300, 1);
    repeat (10) cyc();
    chk("overflow_cleared", 32'(overflow), 0);
    chk("frame_count_cleared", 32'(frame_count), 0);
    chk("valid_disabled", 32'(st.valid), 0);
    mdl_dv = 0;
    enable = 1'b1;

    // Reset mid-line; the remainder of the interrupted frame must produce nothing.
    mon_off  = 1'b1;
    cam_fval = 1'b1;
    repeat (12) cyc();
    cam_lval = 1'b1;
    cam_d = DW'('h111); cyc();
    cam_d = DW'('h112); cyc();
    cam_d = DW'('h113);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    exp_q.delete();
    cyc();
    cam_d = DW'('h114);
    cyc();
    reset_n = 1'b1;
    mon_off = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cam_d = DW'('h115 + i);
      cyc();
    end
    cam_lval = 1'b0;
    repeat (4) cyc();
    cam_fval = 1'b0;
    repeat (6) cyc();
    chk("valid_after_reset", 32'(st.valid), 0);

    push_frame(4, 2, 'hA01);
    drive_frame(4, 2, 'hA01, -1);
    wait_drain("drain_post_reset");
    chk("frame_count_post_reset", 32'(frame_count), 1);
    mdl_dv = 1; mdl_w = 4; mdl_h = 2;

    push_frame(3, 5, 'h5FE);
    drive_frame(3, 5, 'h5FE, -1);
    wait_drain("drain_3x5");
    chk("frame_count_3x5", 32'(frame_count), 2);
    chk("overflow_final", 32'(overflow), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
